mc_control_fsm: RTL
===================

// Module: mc_control_fsm
// PURPOSE
//  Main sequencing FSM for the multicycle MIPS datapath. Issues IRwrite to the instruction
//  register, plus all PC, memory, register-file and ALU-mux controls, one state per cycle.
//  Decodes the IR opcode field. Stalls on a memory ready handshake. Sits beside the ALU
//  decoder, which consumes alu_op and the IR funct field.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: memory states wait for mem_ready; 0: mem_ready ignored, treated as 1
//  STATE_W        4  width of the state register and of the state_o debug port
// PORTS
//  clk          in   1        system clock; all state changes on posedge
//  rst_n        in   1        asynchronous, active-low reset
//  opcode       in   6        IR[31:26] from the instruction register
//  mem_ready    in   1        memory has completed the current read or write this cycle
//  ir_write     out  1        load instruction register (IRwrite)
//  pc_write     out  1        unconditional PC load
//  pc_write_cond out 1        PC load if ALU zero (beq)
//  iord         out  1        0: address = PC; 1: address = ALUOut
//  mem_read     out  1        memory read request
//  mem_write    out  1        memory write request
//  mem_to_reg   out  1        register-file write data: 1 = MDR, 0 = ALUOut
//  reg_dst      out  1        destination: 1 = rd, 0 = rt
//  reg_write    out  1        register-file write enable
//  alu_src_a    out  1        0: PC; 1: A register
//  alu_src_b    out  2        00: B; 01: const 4; 10: sign-ext imm; 11: sign-ext imm<<2
//  alu_op       out  2        00: add; 01: sub; 10: use funct
//  pc_src       out  2        00: ALU result; 01: ALUOut; 10: jump target; 11: exception vector
//  exc          out  1        illegal-opcode exception pulse (EPC/cause load)
//  state_o      out  STATE_W  current state, for debug only
// BEHAVIOUR
//  - Moore FSM. Outputs are a combinational decode of the registered state, plus mem_ready
//    qualification where noted. Any output not listed for a state is 0.
//  - Reset (rst_n=0, async): state <= FETCH. Outputs are then the FETCH decode with
//    mem_ready=0, so ir_write = pc_write = 0 and no write enable is active.
//  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
//    ir_write = pc_write = mem_ready. Go to DECODE on mem_ready, else stay.
//  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next state by opcode:
//    lw 0x23 / sw 0x2B -> MEMADR; R-type 0x00 -> RTYPEEX; beq 0x04 -> BEQEX;
//    addi 0x08 -> ADDIEX; j 0x02 -> JEX; any other -> ILLEGAL path (see CONFIGURATION).
//  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD if lw, else MEMWR.
//  - MEMRD: mem_read=1, iord=1. Hold until mem_ready, then MEMWB.
//  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
//  - MEMWR: mem_write=1, iord=1. mem_write stays high until mem_ready, then FETCH.
//  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10. Then RTYPEWB.
//  - RTYPEWB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
//  - BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1. Then FETCH.
//  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Then ADDIWB.
//  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
//  - JEX: pc_write=1, pc_src=10. Then FETCH.
//  - Latency (MEM_HANDSHAKE=0): lw 5 cycles; sw, R-type, addi 4; beq, j 3.
//    Each wait cycle in a memory state adds 1.
//  - mem_ready is ignored outside FETCH, MEMRD and MEMWR.
//  - opcode is sampled only in DECODE and MEMADR; the IR is stable there because ir_write=0.
//  - Unreachable state encodings -> FETCH on the next clock; outputs all 0 meanwhile.
//  - rst_n low mid-instruction aborts it: no write enable is asserted after reset assertion.
// CONFIGURATION
//  MC_CONTROL_EXC_EN defined: illegal opcode in DECODE -> EXC state for 1 cycle with
//    exc=1, pc_write=1, pc_src=11; then FETCH.
//  MC_CONTROL_EXC_EN undefined: illegal opcode in DECODE -> FETCH (executes as a nop);
//    exc tied 0; pc_src never 11; EXC state not built.
// STRUCTURE
//  - Package mc_pkg holds:
//    - state enum/localparams (FETCH..EXC);
//    - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
//    - alu_src_b, alu_op and pc_src encodings.
//  - Single module: state register plus next-state/output always blocks. No sub-module.
// TESTING
//  - Reset: rst_n=0 mid-MEMWR -> state_o=FETCH at once, mem_write=0, ir_write=0.
//  - lw, MEMD_HANDSHAKE=1, mem_ready 2 cycles late in FETCH and MEMRD ->
//    states FETCH,FETCH,FETCH,DECODE,MEMADR,MEMRD,MEMRD,MEMRD,MEMWB;
//    reg_write=1 only in MEMWB; ir_write pulses once.
//  - R-type (opcode 0x00), mem_ready=1 -> 4 cycles; alu_op=10 in RTYPEEX; reg_dst=1 with reg_write.
//  - beq 0x04 then j 0x02 -> pc_write_cond=1 with pc_src=01 in BEQEX;
//    pc_write=1 with pc_src=10 in JEX; 3 cycles each.
//  - sw with mem_ready held 0 for 5 cycles -> mem_write stays 1 for 6 cycles,
//    iord=1 throughout, then FETCH.
//  - Opcode 0x3F: with MC_CONTROL_EXC_EN -> exc=1, pc_src=11 one cycle after DECODE;
//    without it -> next state FETCH, exc=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS control FSM: state encodings,
// opcodes and the datapath mux/ALU select encodings.
package mc_pkg;

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;
  localparam logic [3:0] EXC     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ASB_B     = 2'b00;
  localparam logic [1:0] ASB_FOUR  = 2'b01;
  localparam logic [1:0] ASB_IMM   = 2'b10;
  localparam logic [1:0] ASB_IMMSH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

endpackage

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM (Moore, one state per cycle).
// Define MC_CONTROL_EXC_EN to trap illegal opcodes through the EXC state.
import mc_pkg::*;

module mc_control_fsm #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               exc,
  output logic [STATE_W-1:0] state_o
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               rdy;

  // Gating with rst_n keeps every write enable low while reset is held.
  assign rdy     = ((MEM_HANDSHAKE != 0) ? mem_ready : 1'b1) & rst_n;
  assign state_o = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STATE_W'(FETCH);
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = STATE_W'(FETCH);
    case (state_q)
      STATE_W'(FETCH):   state_d = rdy ? STATE_W'(DECODE) : STATE_W'(FETCH);
      STATE_W'(DECODE): begin
        case (opcode)
          OP_LW, OP_SW: state_d = STATE_W'(MEMADR);
          OP_RTYPE:     state_d = STATE_W'(RTYPEEX);
          OP_BEQ:       state_d = STATE_W'(BEQEX);
          OP_ADDI:      state_d = STATE_W'(ADDIEX);
          OP_J:         state_d = STATE_W'(JEX);
`ifdef MC_CONTROL_EXC_EN
          default:      state_d = STATE_W'(EXC);
`else
          default:      state_d = STATE_W'(FETCH);
`endif
        endcase
      end
      STATE_W'(MEMADR):  state_d = (opcode == OP_LW) ? STATE_W'(MEMRD) : STATE_W'(MEMWR);
      STATE_W'(MEMRD):   state_d = rdy ? STATE_W'(MEMWB) : STATE_W'(MEMRD);
      STATE_W'(MEMWR):   state_d = rdy ? STATE_W'(FETCH) : STATE_W'(MEMWR);
      STATE_W'(RTYPEEX): state_d = STATE_W'(RTYPEWB);
      STATE_W'(ADDIEX):  state_d = STATE_W'(ADDIWB);
      default:           state_d = STATE_W'(FETCH);
    endcase
  end

  // Unlisted and unreachable states fall through to the all-zero defaults.
  always_comb begin
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ASB_B;
    alu_op        = ALU_ADD;
    pc_src        = PC_ALU;
    exc           = 1'b0;
    case (state_q)
      STATE_W'(FETCH): begin
        mem_read  = 1'b1;
        alu_src_b = ASB_FOUR;
        ir_write  = rdy;
        pc_write  = rdy;
      end
      STATE_W'(DECODE):  alu_src_b = ASB_IMMSH;
      STATE_W'(MEMADR): begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
      end
      STATE_W'(MEMRD): begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      STATE_W'(MEMWB): begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      STATE_W'(MEMWR): begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      STATE_W'(RTYPEEX): begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      STATE_W'(RTYPEWB): begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      STATE_W'(BEQEX): begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_src        = PC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      STATE_W'(ADDIEX): begin
        alu_src_a = 1'b1;
        alu_src_b = ASB_IMM;
      end
      STATE_W'(ADDIWB):  reg_write = 1'b1;
      STATE_W'(JEX): begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
      end
`ifdef MC_CONTROL_EXC_EN
      STATE_W'(EXC): begin
        exc      = 1'b1;
        pc_write = 1'b1;
        pc_src   = PC_EXC;
      end
`endif
      default: ;
    endcase
  end

endmodule
